// File: rtl/idct_pkg.sv
// Shared types and constants for the IDCT row/column sequencer.
package idct_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_FINISH  = 3'd3,
    ST_ERROR   = 3'd4
  } idct_seq_state_t;

  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

  localparam int IDCT_N_DEFAULT = 8;

endpackage

// File: rtl/idct_seq_wdog.sv
// MAC watchdog: down-counter reloaded on i_clear, decremented while i_enable.
// o_expired flags the TIMEOUT-th enabled cycle since the last clear.
module idct_seq_wdog #(
  parameter  int TIMEOUT = 64,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= RELOAD;
    end else if (i_clear) begin
      r_cnt <= RELOAD;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_enable && (r_cnt == '0);

endmodule

// File: rtl/idct_seq_ctrl.sv
// Row/column vector sequencer for the NxN IDCT MAC array and transpose buffer.
// Optional MAC watchdog and ERROR state enabled by defining IDCT_SEQ_WDOG_EN.
module idct_seq_ctrl
  import idct_pkg::*;
#(
  parameter  int N       = IDCT_N_DEFAULT,
  parameter  int TIMEOUT = 64,
  localparam int IDXW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_mode_1d,
  input  logic            i_abort,
  input  logic            i_mac_done,
  output logic            o_load_vec,
  output logic            o_mac_enable,
  output logic            o_pass,
  output logic [IDXW-1:0] o_vec_idx,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  if (N < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("idct_seq_ctrl: N must be >= 2 and TIMEOUT >= 1");
  end

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  idct_seq_state_t r_state, w_state_nxt;
  logic            r_pass, w_pass_nxt;
  logic [IDXW-1:0] r_vec_idx, w_idx_nxt;
  logic            r_mode_1d, w_mode_nxt;
  logic            w_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pass    <= PASS_ROW;
      r_vec_idx <= '0;
      r_mode_1d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pass    <= w_pass_nxt;
      r_vec_idx <= w_idx_nxt;
      r_mode_1d <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass;
    w_idx_nxt   = r_vec_idx;
    w_mode_nxt  = r_mode_1d;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
          w_pass_nxt  = PASS_ROW;
          w_idx_nxt   = '0;
          w_mode_nxt  = i_mode_1d;
        end
      end
      ST_LOAD:    w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: begin
        // mac_done in the last allowed cycle wins over the watchdog
        if (i_mac_done) begin
          if (r_vec_idx != IDX_LAST) begin
            w_idx_nxt   = r_vec_idx + 1'b1;
            w_state_nxt = ST_LOAD;
          end else if (r_pass == PASS_ROW && !r_mode_1d) begin
            w_pass_nxt  = PASS_COL;
            w_idx_nxt   = '0;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      ST_ERROR:  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (i_abort && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      w_pass_nxt  = PASS_ROW;
      w_idx_nxt   = '0;
    end
  end

`ifdef IDCT_SEQ_WDOG_EN
  logic r_err;

  idct_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == ST_LOAD),
    .i_enable  (r_state == ST_COMPUTE),
    .o_expired (w_expired)
  );

  // err is set on entry to ERROR so it is already visible in the ERROR cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_err <= 1'b0;
    end else if (w_state_nxt == ST_ERROR) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_expired = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_load_vec   = (r_state == ST_LOAD);
  assign o_mac_enable = (r_state == ST_COMPUTE);
  assign o_pass       = r_pass;
  assign o_vec_idx    = r_vec_idx;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_FINISH);

endmodule

// File: tb/tb_idct_seq_ctrl.sv
// Scoreboard bench for idct_seq_ctrl: expected load/done events are queued by
// the stimulus and checked by an independent monitor.
module tb_idct_seq_ctrl;

  localparam int N    = 8;
  localparam int TMO  = 4;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start, i_mode_1d, i_abort, i_mac_done;
  logic            o_load_vec, o_mac_enable, o_pass, o_busy, o_done, o_err;
  logic [IDXW-1:0] o_vec_idx;

  idct_seq_ctrl #(.N(N), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_mode_1d    (i_mode_1d),
    .i_abort      (i_abort),
    .i_mac_done   (i_mac_done),
    .o_load_vec   (o_load_vec),
    .o_mac_enable (o_mac_enable),
    .o_pass       (o_pass),
    .o_vec_idx    (o_vec_idx),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    bit pass;
    int idx;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_frame(input int c0, input bit m1d, input int dv, input int dl,
                                     input int stop_p, input int stop_k);
    int  t;
    ev_t e;
    t = c0 + 1;
    for (int p = 0; p <= (m1d ? 0 : 1); p++) begin
      for (int k = 0; k < N; k++) begin
        e.is_done = 1'b0; e.pass = p[0]; e.idx = k; e.at = t;
        exp_q.push_back(e);
        if (p == stop_p && k == stop_k) return;
        t += 1 + ((p == 0 && k == dv) ? dl : 1);
      end
    end
    e.is_done = 1'b1; e.pass = 1'b0; e.idx = 0; e.at = t;
    exp_q.push_back(e);
  endfunction

  // monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (o_load_vec || o_done)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, o_done, o_load_vec}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(e.is_done ? "done_cycle" : "load_cycle", cyc, e.at);
          chk(e.is_done ? "done_kind" : "load_kind", {30'd0, o_done, o_load_vec},
              e.is_done ? 32'd2 : 32'd1);
          if (!e.is_done) begin
            chk("load_pass", {31'd0, o_pass}, {31'd0, e.pass});
            chk("load_idx", {29'd0, o_vec_idx}, e.idx);
          end
        end
      end
    end
  end

  // driver state, written only by the stimulus process
  int dvec = -1, dlen = 1, ccnt = 0, run_len = 0, abort_cyc = 0;
  int busy_cnt = 0, pass_hi = 0;
  bit wd_hold = 0, stray_en = 0, abort_arm = 0;

  task automatic step();
    logic md;
    @(negedge clk);
    if (o_busy) busy_cnt++;
    if (o_busy && o_pass) pass_hi++;
    if (o_mac_enable) begin
      ccnt++;
      md = !wd_hold && (ccnt >= ((o_pass == 1'b0 && o_vec_idx == dvec) ? dlen : 1));
      if (md && o_pass == 1'b0 && o_vec_idx == dvec) run_len = ccnt;
    end else begin
      ccnt = 0;
      md = stray_en && !o_busy;
    end
    i_mac_done = md;
    if (abort_arm && md && o_pass && o_vec_idx == 4) begin
      i_abort   = 1'b1;
      abort_arm = 1'b0;
      abort_cyc = cyc;
    end else begin
      i_abort = 1'b0;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic kick(input bit m1d, input int dv, input int dl, input int sp, input int sk,
                      output int c0);
    step();
    i_start   = 1'b1;
    i_mode_1d = m1d;
    c0        = cyc;
    push_frame(c0, m1d, dv, dl, sp, sk);
    step();
    i_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int c0;
    rst = 1'b1; i_start = 0; i_mode_1d = 0; i_abort = 0; i_mac_done = 0;
    #1;
    chk("rst_load_vec", {31'd0, o_load_vec}, 0);
    chk("rst_mac_enable", {31'd0, o_mac_enable}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_err", {31'd0, o_err}, 0);
    chk("rst_pass", {31'd0, o_pass}, 0);
    chk("rst_idx", {29'd0, o_vec_idx}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 2-D frame, mac_done on every COMPUTE cycle
    busy_cnt = 0;
    kick(1'b0, -1, 1, -1, -1, c0);
    run_to(c0 + 33);
    chk("2d_done_pulse", {31'd0, o_done}, 1);
    step();
    chk("2d_busy_fall", {31'd0, o_busy}, 0);
    chk("2d_busy_cycles", busy_cnt, 33);

    // 1-D frame
    busy_cnt = 0; pass_hi = 0;
    kick(1'b1, -1, 1, -1, -1, c0);
    run_to(c0 + 17);
    chk("1d_done_pulse", {31'd0, o_done}, 1);
    step();
    chk("1d_busy_cycles", busy_cnt, 17);
    chk("1d_pass_stays_row", pass_hi, 0);

    // vector 3 of the row pass takes 5 COMPUTE cycles
    dvec = 3; dlen = 5; run_len = 0;
    kick(1'b0, 3, 5, -1, -1, c0);
    run_to(c0 + 37);
    chk("delay_done", {31'd0, o_done}, 1);
    chk("delay_mac_enable_len", run_len, 5);
    dvec = -1; dlen = 1;
    step();

    // abort coincident with mac_done at pass=1, vec_idx=4
    abort_arm = 1'b1;
    kick(1'b0, -1, 1, 1, 4, c0);
    run_to(c0 + 27);
    chk("abort_cycle", abort_cyc, c0 + 26);
    chk("abort_busy", {31'd0, o_busy}, 0);
    chk("abort_pass", {31'd0, o_pass}, 0);
    chk("abort_idx", {29'd0, o_vec_idx}, 0);
    repeat (4) step();
    kick(1'b0, -1, 1, -1, -1, c0);
    run_to(c0 + 33);
    chk("post_abort_done", {31'd0, o_done}, 1);
    step();

`ifdef IDCT_SEQ_WDOG_EN
    // withheld mac_done trips the watchdog after TMO COMPUTE cycles
    wd_hold = 1'b1;
    kick(1'b1, -1, 1, 0, 0, c0);
    run_to(c0 + 5);
    chk("wd_last_compute", {31'd0, o_mac_enable}, 1);
    chk("wd_err_not_yet", {31'd0, o_err}, 0);
    step();
    chk("wd_error_state_busy", {31'd0, o_busy}, 1);
    chk("wd_error_state_mac", {31'd0, o_mac_enable}, 0);
    chk("wd_error_err", {31'd0, o_err}, 1);
    step();
    chk("wd_idle_busy", {31'd0, o_busy}, 0);
    chk("wd_idle_err", {31'd0, o_err}, 1);
    wd_hold = 1'b0;
    // mac_done in the last allowed cycle: no error, err cleared by start
    dvec = 0; dlen = TMO;
    kick(1'b1, 0, TMO, -1, -1, c0);
    chk("wd_err_cleared", {31'd0, o_err}, 0);
    run_to(c0 + 20);
    chk("wd_edge_done", {31'd0, o_done}, 1);
    chk("wd_edge_err", {31'd0, o_err}, 0);
    dvec = -1; dlen = 1;
    step();
`else
    // without the watchdog COMPUTE waits indefinitely; abort recovers
    wd_hold = 1'b1;
    kick(1'b1, -1, 1, 0, 0, c0);
    run_to(c0 + 40);
    chk("nowd_still_compute", {31'd0, o_mac_enable}, 1);
    chk("nowd_err", {31'd0, o_err}, 0);
    wd_hold = 1'b0;
    i_abort = 1'b1;
    step();
    chk("nowd_abort_idle", {31'd0, o_busy}, 0);
    step();
`endif

    // start held high: back-to-back frames, stray mac_done while idle
    stray_en = 1'b1;
    step();
    i_start = 1'b1; i_mode_1d = 1'b1; c0 = cyc;
    push_frame(c0, 1'b1, -1, 1, -1, -1);
    push_frame(c0 + 18, 1'b1, -1, 1, -1, -1);
    run_to(c0 + 18);
    chk("b2b_idle_gap", {31'd0, o_busy}, 0);
    run_to(c0 + 19);
    chk("b2b_second_load", {31'd0, o_load_vec}, 1);
    i_start = 1'b0;
    run_to(c0 + 35);
    chk("b2b_second_done", {31'd0, o_done}, 1);
    repeat (5) step();
    chk("b2b_stays_idle", {31'd0, o_busy}, 0);
    stray_en = 1'b0;

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
